// File: rtl/ma_multi_ch_pkg.sv
// Shared definitions for the multi-channel moving-average filter.
package ma_multi_ch_pkg;

  // Accumulator width: sample width plus headroom for a full window of samples.
  function automatic int unsigned acc_width(input int unsigned w_in,
                                            input int unsigned log2_max_len);
    return w_in + log2_max_len;
  endfunction

endpackage

// File: rtl/ma_multi_ch_delay_line.sv
// Circular sample buffer for one lane: synchronous write, asynchronous read.
module ma_multi_ch_delay_line #(
  parameter int unsigned Width = 71,
  parameter int unsigned AddrW = 4
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic [AddrW-1:0] wr_addr_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic [AddrW-1:0] rd_addr_i,
  output logic [Width-1:0] rd_data_o
);

  localparam int unsigned Depth = 2 ** AddrW;

  // Not reset: consumers mask stale entries until the window has filled.
  logic [Width-1:0] mem_q [Depth];

  // Write port; a read of the same address this cycle still sees the old word.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/ma_multi_ch.sv
// Multi-lane moving-average filter with runtime window length 2**len_log2.
module ma_multi_ch
  import ma_multi_ch_pkg::*;
#(
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned W_IN         = 71,
  parameter int unsigned LOG2_MAX_LEN = 4,
  parameter int unsigned W_LEN        = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   clear,
  input  logic [W_LEN-1:0]       len_log2,
  input  logic                   in_valid,
  input  logic [NUM_CH*W_IN-1:0] in_data,
  output logic                   out_valid,
  output logic [NUM_CH*W_IN-1:0] out_data,
  output logic                   primed
);

  localparam int unsigned WAcc  = acc_width(W_IN, LOG2_MAX_LEN);
  localparam int unsigned WFill = LOG2_MAX_LEN + 1;

  logic [W_LEN-1:0]        len_q, len_d;
  logic [LOG2_MAX_LEN-1:0] wr_ptr_q, wr_ptr_d;
  logic [WFill-1:0]        fill_q, fill_d;
  logic                    primed_q, primed_d;
  logic                    out_valid_q, out_valid_d;

  logic [W_LEN-1:0]        len_eff;
  logic [WFill-1:0]        len_l;
  logic [LOG2_MAX_LEN-1:0] rd_ptr;
  logic signed [WAcc-1:0]  rnd;
  logic                    full;
  logic                    accept;
  logic                    flush;

  // Window length decode, clamped to the delay-line depth.
  always_comb begin
    len_eff = (len_q > W_LEN'(LOG2_MAX_LEN)) ? W_LEN'(LOG2_MAX_LEN) : len_q;
    len_l   = WFill'(1) << len_eff;
    // Oldest sample sits L entries behind the write pointer (wraps to wr_ptr for max L).
    rd_ptr  = wr_ptr_q - len_l[LOG2_MAX_LEN-1:0];
    // Half an LSB of the result; zero when L == 1.
    rnd     = $signed(WAcc'(len_l >> 1));
    full    = (fill_q == len_l);
  end

  // Shared control: accept/flush decode, pointer, fill and primed tracking.
  always_comb begin
    // A length change flushes like clear so the running sum never mixes windows.
    flush       = en && (clear || (len_log2 != len_q));
    accept      = en && in_valid && !flush;
    len_d       = en ? len_log2 : len_q;
    wr_ptr_d    = wr_ptr_q;
    fill_d      = fill_q;
    primed_d    = primed_q;
    out_valid_d = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      fill_d   = '0;
      primed_d = 1'b0;
    end else if (accept) begin
      wr_ptr_d    = wr_ptr_q + 1'b1;
      fill_d      = full ? fill_q : fill_q + WFill'(1);
      primed_d    = (fill_d == len_l);
      out_valid_d = 1'b1;
    end
  end

  // Shared control state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q       <= '0;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      primed_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      len_q       <= len_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      primed_q    <= primed_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign primed    = primed_q;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    logic [W_IN-1:0]        x;
    logic [W_IN-1:0]        old_raw;
    logic [W_IN-1:0]        old;
    logic signed [WAcc-1:0] sum_q, sum_d;
    logic signed [WAcc-1:0] rounded;
    logic [W_IN-1:0]        avg;
    logic [W_IN-1:0]        avg_q;

    assign x = in_data[k*W_IN +: W_IN];

    ma_multi_ch_delay_line #(
      .Width (W_IN),
      .AddrW (LOG2_MAX_LEN)
    ) u_delay_line (
      .clk       (clk),
      .wr_en_i   (accept),
      .wr_addr_i (wr_ptr_q),
      .wr_data_i (x),
      .rd_addr_i (rd_ptr),
      .rd_data_o (old_raw)
    );

    // Running sum update and rounded average of the post-update sum.
    always_comb begin
      old   = full ? old_raw : '0;
      sum_d = sum_q;
      if (flush) begin
        sum_d = '0;
      end else if (accept) begin
        // Wrap of the intermediate sum is harmless: the final sum always fits.
        sum_d = sum_q + $signed({{LOG2_MAX_LEN{x[W_IN-1]}}, x})
                      - $signed({{LOG2_MAX_LEN{old[W_IN-1]}}, old});
      end
      rounded = sum_d + rnd;
      avg     = W_IN'(rounded >>> len_eff);
    end

    // Per-lane accumulator and held output.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_q <= '0;
        avg_q <= '0;
      end else begin
        sum_q <= sum_d;
        if (accept) begin
          avg_q <= avg;
        end
      end
    end

    assign out_data[k*W_IN +: W_IN] = avg_q;
  end

endmodule

// File: tb/tb_ma_multi_ch.sv
// Directed self-checking bench for ma_multi_ch (2 lanes, 71-bit samples, max window 16).
module tb_ma_multi_ch;

  localparam int unsigned W = 71;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           en;
  logic           clear;
  logic [2:0]     len_log2;
  logic           in_valid;
  logic [2*W-1:0] in_data;
  logic           out_valid;
  logic [2*W-1:0] out_data;
  logic           primed;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] min_v;
  logic [W-1:0] max_v;

  ma_multi_ch #(
    .NUM_CH       (2),
    .W_IN         (W),
    .LOG2_MAX_LEN (4),
    .W_LEN        (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .clear     (clear),
    .len_log2  (len_log2),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .primed    (primed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Check all outputs: valid, primed and both lanes.
  task automatic chk_out(input string tag, input logic ov, input logic pr,
                         input logic [W-1:0] e0, input logic [W-1:0] e1);
    chk({tag, ".valid"}, W'(out_valid), W'(ov));
    chk({tag, ".primed"}, W'(primed), W'(pr));
    chk({tag, ".lane0"}, out_data[W-1:0], e0);
    chk({tag, ".lane1"}, out_data[2*W-1:W], e1);
  endtask

  // Drive one cycle of inputs away from the edge, return just after the edge.
  task automatic push(input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    in_valid = v;
    in_data  = {b, a};
    @(posedge clk);
    #1;
  endtask

  initial begin
    min_v = {1'b1, {(W-1){1'b0}}};
    max_v = {1'b0, {(W-1){1'b1}}};
    rst_n = 1'b0; en = 1'b0; clear = 1'b0; len_log2 = 3'd0;
    in_valid = 1'b0; in_data = '0;
    #12;
    chk_out("reset", 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    push(1'b0, 0, 0);
    push(1'b0, 0, 0);
    chk_out("idle", 1'b0, 1'b0, 0, 0);

    // L = 4: constant +8 / -8 ramps up over four samples.
    len_log2 = 3'd2;
    push(1'b0, 0, 0);
    push(1'b1, 8, -8); chk_out("l4_s1", 1'b1, 1'b0, 2, -2);
    push(1'b1, 8, -8); chk_out("l4_s2", 1'b1, 1'b0, 4, -4);
    push(1'b1, 8, -8); chk_out("l4_s3", 1'b1, 1'b0, 6, -6);
    push(1'b1, 8, -8); chk_out("l4_s4", 1'b1, 1'b1, 8, -8);
    push(1'b1, 8, -8); chk_out("l4_s5", 1'b1, 1'b1, 8, -8);
    push(1'b0, 0, 0);  chk_out("l4_idle", 1'b0, 1'b1, 8, -8);
    // Disabled: sample ignored, outputs hold.
    en = 1'b0;
    push(1'b1, 0, 0);  chk_out("l4_en0", 1'b0, 1'b1, 8, -8);
    en = 1'b1;

    // L = 2: sliding window and round-half-up on both signs.
    len_log2 = 3'd1;
    push(1'b0, 0, 0);
    push(1'b1, 1, -1); chk_out("l2_s1", 1'b1, 1'b0, 1, 0);
    push(1'b1, 3, -2); chk_out("l2_s2", 1'b1, 1'b1, 2, -1);
    push(1'b1, 5, 0);  chk_out("l2_s3", 1'b1, 1'b1, 4, -1);
    push(1'b1, 7, 0);  chk_out("l2_s4", 1'b1, 1'b1, 6, 0);

    // L = 16: full-scale negative then positive, no wrap.
    len_log2 = 3'd4;
    push(1'b0, 0, 0);
    for (int i = 1; i <= 20; i++) begin
      push(1'b1, min_v, min_v);
      if (i == 15) chk("l16_min_s15.primed", W'(primed), W'(1'b0));
      if (i == 16) chk_out("l16_min_s16", 1'b1, 1'b1, min_v, min_v);
    end
    chk_out("l16_min_s20", 1'b1, 1'b1, min_v, min_v);
    for (int i = 1; i <= 16; i++) push(1'b1, max_v, max_v);
    chk_out("l16_max", 1'b1, 1'b1, max_v, max_v);

    // L = 8: clear with a coincident sample drops it.
    len_log2 = 3'd3;
    push(1'b0, 0, 0);
    for (int i = 0; i < 10; i++) push(1'b1, 100, -100);
    chk_out("l8_pre", 1'b1, 1'b1, 100, -100);
    clear = 1'b1;
    push(1'b1, 100, -100); chk_out("l8_clear", 1'b0, 1'b0, 100, -100);
    clear = 1'b0;
    push(1'b1, 100, -100); chk_out("l8_after", 1'b1, 1'b0, 13, -12);

    // Length change 2 -> 3 mid-stream flushes and drops the coincident sample.
    len_log2 = 3'd2;
    push(1'b0, 0, 0);
    push(1'b1, 8, -8); chk_out("chg_s1", 1'b1, 1'b0, 2, -2);
    push(1'b1, 8, -8); chk_out("chg_s2", 1'b1, 1'b0, 4, -4);
    len_log2 = 3'd3;
    push(1'b1, 8, -8); chk_out("chg_edge", 1'b0, 1'b0, 4, -4);
    push(1'b1, 8, -8); chk_out("chg_l8", 1'b1, 1'b0, 1, -1);

    // len_log2 = 7 behaves as a 16-sample window.
    len_log2 = 3'd7;
    push(1'b1, 16, -16); chk_out("clamp_edge", 1'b0, 1'b0, 1, -1);
    push(1'b1, 16, -16); chk_out("clamp_s1", 1'b1, 1'b0, 1, -1);
    for (int i = 2; i <= 15; i++) push(1'b1, 16, -16);
    chk("clamp_s15.primed", W'(primed), W'(1'b0));
    push(1'b1, 16, -16); chk_out("clamp_s16", 1'b1, 1'b1, 16, -16);

    // Asynchronous reset mid-stream.
    push(1'b1, 5, -5);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("mid_reset", 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    repeat (3) push(1'b0, 0, 0);
    chk_out("post_reset", 1'b0, 1'b0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
